sram_responder: RTL and testbench



---
 rtl/sram_responder.sv | 157 +++++++++++++++
 tb/tb_sram_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// sram_responder: single-port word memory shared between a CPU port that is
// never stalled and a req/ack host port that is served only in cycles the CPU
// leaves idle. Tracks CPU access counts and flags host starvation.
module sram_responder #(
  parameter int DEPTH_LOG2   = 10,
  parameter int STARVE_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_EN,
  input  logic        sram_WE,
  input  logic [15:0] sram_ADDR,
  input  logic [31:0] sram_DI,
  output logic [31:0] sram_DO,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_ack,
  output logic [31:0] host_rdata,
  output logic        host_starve,
  output logic [15:0] cpu_rd_cnt,
  output logic [15:0] cpu_wr_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int BW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(STARVE_LIMIT);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   host_go;

  logic [31:0] mem [0:DEPTH-1];

  logic [DEPTH_LOG2-1:0] cpu_idx;
  logic [DEPTH_LOG2-1:0] host_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [31:0]           wr_data;
  logic                  wr_en;
  logic                  cpu_rd;
  logic                  cpu_wr;

  logic [31:0]   sram_do_q;
  logic [31:0]   host_rdata_q;
  logic [BW-1:0] blk_q, blk_d;
  logic          starve_q, starve_d;
  logic [15:0]   rd_cnt_q, rd_cnt_d;
  logic [15:0]   wr_cnt_q, wr_cnt_d;

  // Upper address bits are deliberately ignored so addresses wrap.
  assign cpu_idx  = sram_ADDR[DEPTH_LOG2-1:0];
  assign host_idx = host_addr[DEPTH_LOG2-1:0];

  generate
    if (DEPTH_LOG2 < 16) begin : g_addr_unused
      logic unused_addr_bits;
      assign unused_addr_bits = ^{sram_ADDR[15:DEPTH_LOG2], host_addr[15:DEPTH_LOG2]};
    end
  endgenerate

  assign cpu_rd = sram_EN & ~sram_WE;
  assign cpu_wr = sram_EN & sram_WE;

  // Host FSM next state: the access happens on the IDLE->ACK edge, and only
  // when the CPU leaves the port free; ACK always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    host_go = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (host_req && !sram_EN) begin
          host_go = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Host FSM state register; reset in ACK drops straight to IDLE.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  assign host_ack = (state_q == S_ACK);

  // One shared write port: CPU and host can never write in the same cycle
  // because the host only goes when sram_EN is low.
  assign wr_en   = !reset && (cpu_wr || (host_go && host_we));
  assign wr_idx  = sram_EN ? cpu_idx : host_idx;
  assign wr_data = sram_EN ? sram_DI : host_wdata;

  // Memory array write; contents are intentionally untouched by reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Registered CPU read data, held until the next CPU read.
  always_ff @(posedge clk) begin
    if (reset)       sram_do_q <= 32'h0;
    else if (cpu_rd) sram_do_q <= mem[cpu_idx];
  end

  // Registered host read data, captured on the access edge and held.
  always_ff @(posedge clk) begin
    if (reset)                    host_rdata_q <= 32'h0;
    else if (host_go && !host_we) host_rdata_q <= mem[host_idx];
  end

  // Blocked-cycle counter, starvation flag and saturating CPU counters.
  always_comb begin
    blk_d    = blk_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (!host_req) begin
      blk_d = '0;
    end else if (state_q == S_IDLE) begin
      if (sram_EN) begin
        if (blk_q != BLK_MAX) blk_d = blk_q + BW'(1);
      end else begin
        blk_d = '0;
      end
    end
    starve_d = starve_q | (blk_d == BLK_MAX);
    if (cpu_rd && rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
    if (cpu_wr && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
  end

  // Status and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_q    <= '0;
      starve_q <= 1'b0;
      rd_cnt_q <= 16'h0;
      wr_cnt_q <= 16'h0;
    end else begin
      blk_q    <= blk_d;
      starve_q <= starve_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign sram_DO     = sram_do_q;
  assign host_rdata  = host_rdata_q;
  assign host_starve = starve_q;
  assign cpu_rd_cnt  = rd_cnt_q;
  assign cpu_wr_cnt  = wr_cnt_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: CPU read/write, wrap-around, host
// read/write arbitration, starvation flag and reset-in-ACK behaviour.
module tb_sram_responder;

  logic        clk;
  logic        reset;
  logic        sram_EN;
  logic        sram_WE;
  logic [15:0] sram_ADDR;
  logic [31:0] sram_DI;
  logic [31:0] sram_DO;
  logic        host_req;
  logic        host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic        host_starve;
  logic [15:0] cpu_rd_cnt;
  logic [15:0] cpu_wr_cnt;

  int checks = 0;
  int errors = 0;

  sram_responder #(.DEPTH_LOG2(10), .STARVE_LIMIT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .sram_EN    (sram_EN),
    .sram_WE    (sram_WE),
    .sram_ADDR  (sram_ADDR),
    .sram_DI    (sram_DI),
    .sram_DO    (sram_DO),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .host_starve(host_starve),
    .cpu_rd_cnt (cpu_rd_cnt),
    .cpu_wr_cnt (cpu_wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cpu(input logic en, input logic we, input logic [15:0] a, input logic [31:0] d);
    sram_EN   = en;
    sram_WE   = we;
    sram_ADDR = a;
    sram_DI   = d;
  endtask

  task automatic host(input logic req, input logic we, input logic [15:0] a, input logic [31:0] d);
    host_req   = req;
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
  endtask

  initial begin
    reset = 1'b1;
    cpu(0, 0, 16'h0, 32'h0);
    host(0, 0, 16'h0, 32'h0);
    step();
    step();
    chk("rst_do",     sram_DO, 32'h0);
    chk("rst_rdata",  host_rdata, 32'h0);
    chk("rst_ack",    {31'h0, host_ack}, 32'h0);
    chk("rst_starve", {31'h0, host_starve}, 32'h0);
    chk("rst_rdcnt",  {16'h0, cpu_rd_cnt}, 32'h0);
    chk("rst_wrcnt",  {16'h0, cpu_wr_cnt}, 32'h0);
    reset = 1'b0;

    // CPU write then read-after-write of addr 5
    cpu(1, 1, 16'd5, 32'hDEADBEEF);
    step();
    cpu(1, 0, 16'd5, 32'h0);
    step();
    chk("raw_do",    sram_DO, 32'hDEADBEEF);
    chk("raw_wrcnt", {16'h0, cpu_wr_cnt}, 32'd1);
    chk("raw_rdcnt", {16'h0, cpu_rd_cnt}, 32'd1);

    // Wrap-around: 0x0403 aliases 0x0003 with 1024 words
    cpu(1, 1, 16'h0403, 32'h11);
    step();
    cpu(1, 0, 16'h0003, 32'h0);
    step();
    chk("wrap_do", sram_DO, 32'h11);

    // sram_DO holds across idle and CPU write
    cpu(0, 0, 16'h0, 32'h0);
    step();
    chk("hold_idle", sram_DO, 32'h11);
    cpu(1, 1, 16'd7, 32'h77);
    step();
    chk("hold_write", sram_DO, 32'h11);
    chk("wr_cnt3",    {16'h0, cpu_wr_cnt}, 32'd3);

    // Host write to addr 9 with CPU idle
    cpu(0, 0, 16'h0, 32'h0);
    host(1, 1, 16'd9, 32'hCAFE0001);
    step();
    chk("hw_ack1", {31'h0, host_ack}, 32'd1);
    host(0, 0, 16'h0, 32'h0);
    step();
    chk("hw_ack0", {31'h0, host_ack}, 32'd0);
    cpu(1, 0, 16'd9, 32'h0);
    step();
    chk("hw_cpu_rd",  sram_DO, 32'hCAFE0001);
    chk("hw_nocount", {16'h0, cpu_wr_cnt}, 32'd3);

    // Host read blocked by 3 CPU reads, then served
    host(1, 0, 16'd5, 32'h0);
    cpu(1, 0, 16'd7, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("blk_ack0", {31'h0, host_ack}, 32'd0);
    end
    chk("blk_cpu_do", sram_DO, 32'h77);
    cpu(0, 0, 16'h0, 32'h0);
    step();
    chk("hr_ack1",   {31'h0, host_ack}, 32'd1);
    chk("hr_rdata",  host_rdata, 32'hDEADBEEF);
    chk("hr_starve", {31'h0, host_starve}, 32'd0);
    host(0, 0, 16'h0, 32'h0);
    step();
    chk("hr_ack0",     {31'h0, host_ack}, 32'd0);
    chk("hr_rdata_hd", host_rdata, 32'hDEADBEEF);
    chk("rd_cnt6",     {16'h0, cpu_rd_cnt}, 32'd6);

    // Starvation: 16 consecutive blocked cycles
    host(1, 0, 16'h0403, 32'h0);
    cpu(1, 0, 16'd7, 32'h0);
    for (int i = 0; i < 15; i++) step();
    chk("starve_15", {31'h0, host_starve}, 32'd0);
    step();
    chk("starve_16", {31'h0, host_starve}, 32'd1);
    cpu(0, 0, 16'h0, 32'h0);
    step();
    chk("st_ack1",  {31'h0, host_ack}, 32'd1);
    chk("st_rdata", host_rdata, 32'h11);
    host(0, 0, 16'h0, 32'h0);
    step();
    chk("st_sticky", {31'h0, host_starve}, 32'd1);
    chk("rd_cnt22",  {16'h0, cpu_rd_cnt}, 32'd22);

    // Reset during the ACK of a host read; CPU write attempted under reset
    host(1, 0, 16'd9, 32'h0);
    step();
    chk("ra_ack1",  {31'h0, host_ack}, 32'd1);
    chk("ra_rdata", host_rdata, 32'hCAFE0001);
    host(0, 0, 16'h0, 32'h0);
    reset = 1'b1;
    cpu(1, 1, 16'd5, 32'h0);
    step();
    chk("ra_ack0",    {31'h0, host_ack}, 32'd0);
    chk("ra_rdata0",  host_rdata, 32'h0);
    chk("ra_rdcnt0",  {16'h0, cpu_rd_cnt}, 32'd0);
    chk("ra_wrcnt0",  {16'h0, cpu_wr_cnt}, 32'd0);
    chk("ra_starve0", {31'h0, host_starve}, 32'd0);
    chk("ra_do0",     sram_DO, 32'h0);
    reset = 1'b0;
    cpu(0, 0, 16'h0, 32'h0);
    step();
    chk("ra_nodup", {31'h0, host_ack}, 32'd0);
    cpu(1, 0, 16'd5, 32'h0);
    step();
    chk("ra_mem5", sram_DO, 32'hDEADBEEF);
    cpu(1, 0, 16'd9, 32'h0);
    step();
    chk("ra_mem9", sram_DO, 32'hCAFE0001);

    // Request held through ACK is a new request in the next IDLE cycle
    cpu(0, 0, 16'h0, 32'h0);
    host(1, 1, 16'd10, 32'h0000000A);
    step();
    chk("held_ack1", {31'h0, host_ack}, 32'd1);
    step();
    chk("held_ack0", {31'h0, host_ack}, 32'd0);
    step();
    chk("held_ack2", {31'h0, host_ack}, 32'd1);
    host(0, 0, 16'h0, 32'h0);
    step();
    cpu(1, 0, 16'd10, 32'h0);
    step();
    chk("held_mem", sram_DO, 32'h0000000A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
